// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration between ALU and load
// writebacks, one registered write per cycle, and a per-register busy scoreboard.
module regfile_wb_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [NREG-1:0] busy_vec
);

  typedef enum logic {
    SRC_LOAD = 1'b0,
    SRC_ALU  = 1'b1
  } src_e;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  src_e            rr_ptr;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            contested_c;
  logic            grant_alu_c;
  logic            grant_ld_c;
  logic            stall_c;
  logic            issue_c;
  logic            rs1_busy_c;
  logic            rs2_busy_c;
  logic            rd_busy_c;
  wb_req_t         sel_c;

  // Arbitration, hazard detection and next scoreboard state
  always_comb begin
    contested_c = alu_valid & ld_valid;
    grant_alu_c = alu_valid & (~ld_valid | (rr_ptr == SRC_ALU));
    grant_ld_c  = ld_valid & ~grant_alu_c;

    sel_c.rd   = alu_rd;
    sel_c.data = alu_data;
    if (grant_ld_c) begin
      sel_c.rd   = ld_rd;
      sel_c.data = ld_data;
    end

    // x0 is never tracked, so its lookups are forced clear
    rs1_busy_c = (iss_rs1 != '0) & busy_q[iss_rs1];
    rs2_busy_c = (iss_rs2 != '0) & busy_q[iss_rs2];
    rd_busy_c  = (iss_rd  != '0) & busy_q[iss_rd];
    stall_c    = iss_valid & (rs1_busy_c | rs2_busy_c | rd_busy_c);
    issue_c    = iss_valid & ~stall_c & (iss_rd != '0);

    // Clear applied before set so a fresh producer on the same register wins
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (issue_c) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign iss_stall = stall_c;
  assign alu_ready = grant_alu_c;
  assign ld_ready  = grant_ld_c;
  assign busy_vec  = busy_q;

  // Round-robin pointer, registered write port and scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= SRC_LOAD;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy_q  <= '0;
    end else begin
      if (contested_c) begin
        rr_ptr <= (rr_ptr == SRC_LOAD) ? SRC_ALU : SRC_LOAD;
      end
      wr_en <= (grant_alu_c | grant_ld_c) & (sel_c.rd != '0);
      if (grant_alu_c | grant_ld_c) begin
        wr_addr <= sel_c.rd;
        wr_data <= sel_c.data;
      end
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed scenarios then randomized traffic,
// all cycles checked against a behavioural model of arbitration and the busy table.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_vec;

  regfile_wb_scheduler #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: set of outstanding destinations, whose turn it is on a tie,
  // and the list of register-file writes expected in future cycles.
  typedef struct {
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  bit [31:0]   m_busy;
  bit          alu_turn;
  bit          pend_v;
  bit [4:0]    pend_a;

  function automatic bit m_is_busy(input logic [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  bit          m_stall, m_ga, m_gl;
  bit [31:0]   m_next;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_busy_vec", 64'(busy_vec), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      m_busy   = '0;
      alu_turn = 1'b0;
      pend_v   = 1'b0;
      exp_q.delete();
    end else begin
      chk("busy_vec", 64'(busy_vec), 64'(m_busy));
      m_stall = iss_valid && (m_is_busy(iss_rs1) || m_is_busy(iss_rs2) || m_is_busy(iss_rd));
      chk("iss_stall", 64'(iss_stall), 64'(m_stall));
      if (alu_valid && ld_valid) begin
        m_ga = alu_turn;
        m_gl = !alu_turn;
        alu_turn = !alu_turn;
      end else begin
        m_ga = alu_valid;
        m_gl = ld_valid;
      end
      chk("alu_ready", 64'(alu_ready), 64'(m_ga));
      chk("ld_ready", 64'(ld_ready), 64'(m_gl));
      m_next = m_busy;
      if (pend_v) m_next[pend_a] = 1'b0;
      if (iss_valid && !m_stall && iss_rd != 0) m_next[iss_rd] = 1'b1;
      m_busy = m_next;
      pend_v = 1'b0;
      if (m_ga && alu_rd != 0) begin
        exp_q.push_back('{cyc + 1, alu_rd, alu_data});
        pend_v = 1'b1; pend_a = alu_rd;
      end
      if (m_gl && ld_rd != 0) begin
        exp_q.push_back('{cyc + 1, ld_rd, ld_data});
        pend_v = 1'b1; pend_a = ld_rd;
      end
    end
  end

  // Monitor: every cycle either the expected write appears or the port is idle
  wr_t got;
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        got = exp_q.pop_front();
        chk("wr_en", 64'(wr_en), 64'd1);
        chk("wr_addr", 64'(wr_addr), 64'(got.addr));
        chk("wr_data", 64'(wr_data), 64'(got.data));
      end else begin
        chk("wr_en_idle", 64'(wr_en), 64'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  logic [31:0] busy_snap;
  bit          alu_acc, ld_acc, st;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) next_cycle();
    reset = 1'b0;
    next_cycle();

    // Reset while an ALU write is in flight
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h55;
    @(negedge clk) chk("mw_alu_ready", 64'(alu_ready), 64'd1);
    next_cycle();
    alu_valid = 0; reset = 1'b1;
    @(negedge clk);
    chk("mw_wr_en", 64'(wr_en), 64'd0);
    chk("mw_busy", 64'(busy_vec), 64'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Single ALU writeback to x5
    iss_valid = 1; iss_rd = 5'd5;
    next_cycle();
    iss_valid = 0; iss_rd = 0;
    next_cycle();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("sa_alu_ready", 64'(alu_ready), 64'd1);
    chk("sa_busy5_set", 64'(busy_vec[5]), 64'd1);
    next_cycle();
    alu_valid = 0;
    @(negedge clk);
    chk("sa_wr_en", 64'(wr_en), 64'd1);
    chk("sa_wr_addr", 64'(wr_addr), 64'd5);
    chk("sa_wr_data", 64'(wr_data), 64'hDEADBEEF);
    next_cycle();
    @(negedge clk) chk("sa_busy5_clr", 64'(busy_vec[5]), 64'd0);

    // Contention: grants LOAD, ALU, LOAD starting from the reset pointer
    next_cycle();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA1;
    ld_valid  = 1; ld_rd  = 5'd2; ld_data  = 32'hB1;
    @(negedge clk);
    chk("ct1_ld_ready", 64'(ld_ready), 64'd1);
    chk("ct1_alu_ready", 64'(alu_ready), 64'd0);
    next_cycle();
    ld_rd = 5'd3; ld_data = 32'hB2;
    @(negedge clk);
    chk("ct2_alu_ready", 64'(alu_ready), 64'd1);
    chk("ct2_ld_ready", 64'(ld_ready), 64'd0);
    chk("ct2_wr_addr", 64'(wr_addr), 64'd2);
    next_cycle();
    alu_rd = 5'd4; alu_data = 32'hA2;
    @(negedge clk);
    chk("ct3_ld_ready", 64'(ld_ready), 64'd1);
    chk("ct3_alu_ready", 64'(alu_ready), 64'd0);
    chk("ct3_wr_addr", 64'(wr_addr), 64'd1);
    next_cycle();
    ld_valid = 0;
    @(negedge clk) chk("ct4_wr_addr", 64'(wr_addr), 64'd3);
    next_cycle();
    alu_valid = 0;
    next_cycle();

    // RAW then WAW on x7
    iss_valid = 1; iss_rd = 5'd7;
    next_cycle();
    iss_rd = 0; iss_rs1 = 5'd7;
    @(negedge clk) chk("raw_stall", 64'(iss_stall), 64'd1);
    repeat (2) next_cycle();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    next_cycle();
    alu_valid = 0;
    @(negedge clk) chk("raw_stall_wr_cycle", 64'(iss_stall), 64'd1);
    next_cycle();
    @(negedge clk) chk("raw_released", 64'(iss_stall), 64'd0);
    next_cycle();
    iss_rs1 = 0; iss_rd = 5'd7;
    next_cycle();
    @(negedge clk) chk("waw_stall", 64'(iss_stall), 64'd1);
    next_cycle();
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h78;
    next_cycle();
    ld_valid = 0;
    next_cycle();
    @(negedge clk) chk("waw_released", 64'(iss_stall), 64'd0);
    next_cycle();
    iss_valid = 0; iss_rd = 0;
    next_cycle();

    // Load to x0 is accepted but never written
    ld_valid = 1; ld_rd = 0; ld_data = 32'h1234;
    iss_valid = 1; iss_rs1 = 0; iss_rd = 0;
    @(negedge clk);
    chk("x0_ld_ready", 64'(ld_ready), 64'd1);
    chk("x0_stall", 64'(iss_stall), 64'd0);
    busy_snap = busy_vec;
    next_cycle();
    ld_valid = 0; iss_valid = 0;
    @(negedge clk);
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_busy", 64'(busy_vec), 64'(busy_snap));

    // Same-edge clear and set of x9: set wins
    next_cycle();
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
    next_cycle();
    alu_valid = 0;
    iss_valid = 1; iss_rd = 5'd9;
    @(negedge clk);
    chk("col_wr_addr", 64'(wr_addr), 64'd9);
    chk("col_stall", 64'(iss_stall), 64'd0);
    next_cycle();
    iss_valid = 0; iss_rd = 0;
    @(negedge clk) chk("col_busy9", 64'(busy_vec[9]), 64'd1);

    // Randomized traffic from a clean state
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      alu_acc = alu_ready; ld_acc = ld_ready; st = iss_stall;
      next_cycle();
      if (!alu_valid || alu_acc) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!ld_valid || ld_acc) begin
        ld_valid = ($urandom_range(0, 2) != 0);
        ld_rd    = 5'($urandom_range(0, 7));
        ld_data  = $urandom;
      end
      if (!iss_valid || !st) begin
        iss_valid = ($urandom_range(0, 1) != 0);
        iss_rs1   = 5'($urandom_range(0, 7));
        iss_rs2   = 5'($urandom_range(0, 7));
        iss_rd    = 5'($urandom_range(0, 7));
      end
    end
    idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
